// File: rtl/sha256_block_sequencer.sv
// ---------------------------------------------------------------------------
// sha256_block_sequencer
//
// Multi-block message controller that sits in front of the SHA-256 core.
// Message words arrive over a valid/ready stream and are collected into a
// 512-bit block. The core is started once per block, and each block's result
// becomes the IV of the next block. After the final block the digest is
// offered on a valid/ready output. Padding is done upstream.
//
// Optional feature macro: SHA256_SEQ_TIMEOUT_EN
//   When this macro is defined, the sequencer aborts a block if the core has
//   not completed within TIMEOUT_CYCLES cycles of WAIT. It pulses err_timeout
//   and discards the message. When the macro is undefined, err_timeout is tied
//   low and WAIT has no time limit.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT-cycle limit (used only with SHA256_SEQ_TIMEOUT_EN)
//   CNT_W           width of block_count
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-low reset
//   s_word_valid/ready/s_word/s_last   message word stream
//                     (s_last is legal only on word 15)
//   core_start        one-cycle start pulse to the core
//   core_w            {W0..W15}, with W0 in [511:480]
//   core_iv           {H0..H7}, with H0 in [255:224]
//   core_result       core hash result
//   core_done         core done level
//   d_valid/d_ready/d_digest           final digest handshake
//   busy              low only while idle (LOAD with no words buffered)
//   block_count       blocks completed in the current message (saturating)
//   err_proto         one-cycle pulse when s_last is accepted early
//   err_timeout       one-cycle pulse when the core times out
// ---------------------------------------------------------------------------
module sha256_block_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_word_valid,
  output logic             s_word_ready,
  input  logic [31:0]      s_word,
  input  logic             s_last,
  output logic             core_start,
  output logic [511:0]     core_w,
  output logic [255:0]     core_iv,
  input  logic [255:0]     core_result,
  input  logic             core_done,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [255:0]     d_digest,
  output logic             busy,
  output logic [CNT_W-1:0] block_count,
  output logic             err_proto,
  output logic             err_timeout
);

  localparam logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {LOAD, START, WAIT, OUT} state_t;

  state_t       state, state_next;
  logic [3:0]   idx;
  logic [31:0]  word_buf [16];
  logic [255:0] iv;
  logic [255:0] hash;
  logic         last_blk;
  logic         done_q;
  logic         word_xfer;
  logic         proto_bad;
  logic         completion;
  logic         timeout_hit;

  assign word_xfer  = s_word_valid && s_word_ready;
  assign proto_bad  = word_xfer && s_last && (idx != 4'd15);
  // A completion is counted only on a rising edge of core_done. A done level
  // that is still high from the previous block is therefore ignored.
  assign completion = (state == WAIT) && core_done && !done_q;

  // Ready is gated by reset so that every handshake output reads 0 while
  // the sequencer is held in reset.
  assign s_word_ready = (state == LOAD) && reset;
  assign core_start   = (state == START);
  assign d_valid      = (state == OUT);
  assign busy         = !((state == LOAD) && (idx == 4'd0));
  assign core_iv      = iv;
  assign d_digest     = hash;

  always_comb begin
    core_w = '0;
    for (int i = 0; i < 16; i++) begin
      core_w[511 - 32*i -: 32] = word_buf[i];
    end
  end

`ifdef SHA256_SEQ_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] wait_cnt;

  // The counter is cleared in START, so it reads 0 on the first WAIT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == START) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A completion edge in the expiry cycle takes priority over the timeout.
  assign timeout_hit = (state == WAIT) && !completion &&
                       (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (word_xfer && !proto_bad && (idx == 4'd15)) state_next = START;
      end
      START: state_next = WAIT;
      WAIT: begin
        if (completion)       state_next = last_blk ? OUT : LOAD;
        else if (timeout_hit) state_next = LOAD;
      end
      OUT: begin
        if (d_ready) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= LOAD;
      idx         <= 4'd0;
      iv          <= H_INIT;
      hash        <= '0;
      last_blk    <= 1'b0;
      done_q      <= 1'b0;
      block_count <= '0;
      err_proto   <= 1'b0;
      for (int i = 0; i < 16; i++) word_buf[i] <= '0;
    end else begin
      state     <= state_next;
      done_q    <= core_done;
      err_proto <= proto_bad;
      case (state)
        LOAD: begin
          if (word_xfer) begin
            word_buf[idx] <= s_word;
            if (proto_bad) begin
              idx         <= 4'd0;
              iv          <= H_INIT;
              block_count <= '0;
            end else begin
              // idx wraps from 15 back to 0 as the block is handed to the core.
              idx <= idx + 4'd1;
              if (idx == 4'd15) last_blk <= s_last;
            end
          end
        end
        WAIT: begin
          if (completion) begin
            hash <= core_result;
            if (block_count != {CNT_W{1'b1}}) block_count <= block_count + 1'b1;
            if (!last_blk) iv <= core_result;
          end else if (timeout_hit) begin
            iv          <= H_INIT;
            block_count <= '0;
          end
        end
        OUT: begin
          if (d_ready) begin
            iv          <= H_INIT;
            block_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
